scr1_dmem_sram_resp: RTL and testbench
======================================

Name: scr1_dmem_sram_resp

Overview:
Data-memory responder on the core dmem interface. It is the target side of the LSU request/response handshake. It accepts one load/store transaction at a time and stores data in an internal word-organised SRAM array. It applies byte-lane steering: store data is shifted into its lane, and load data is returned right-justified. It returns OKAY/ERROR after a programmable number of wait states. It sits between the pipeline LSU (or dmem router port) and on-chip data RAM.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2, 16..65536).
BASE_ADDR, 32'h0001_0000, byte base address of the window; must be aligned to DEPTH_WORDS*4.
WAIT_CYCLES, 0, extra cycles between acceptance and response (0..15).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dmem_req_i  in  1  request valid
dmem_cmd_i  in  1  0 = read, 1 = write
dmem_width_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal
dmem_addr_i  in  32  byte address
dmem_wdata_i  in  32  store data, right-justified (byte in [7:0], halfword in [15:0])
dmem_req_ack_o  out  1  request accepted this cycle
dmem_rdata_o  out  32  load data, right-justified, not extended
dmem_resp_o  out  2  00 idle, 01 OKAY, 10 ERROR
inj_par_err_i  in  1  parity error injection on write (used only with the optional feature)

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. On reset, FSM goes to IDLE, wait counter = 0, dmem_req_ack_o = 0, dmem_resp_o = 2'b00, dmem_rdata_o = 0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: dmem_req_ack_o = 1 combinationally (1 whenever state is IDLE and not in reset).
  - IDLE with req_i = 1: latch cmd, width, addr, wdata, and an error flag. Load counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: decrement counter; go to RESP when counter reaches 1.
  - RESP: dmem_resp_o is valid for exactly one cycle, then state returns to IDLE.
  - req_ack_o = 0 in WAIT and RESP. A request held high during those states is ignored and is accepted on the next IDLE cycle.
- Latency: acceptance edge to resp_o asserted = 1 + WAIT_CYCLES cycles. Back-to-back requests give a minimum of 2 cycles per transaction.
- Error flag is set when any of the following hold:
  - address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4);
  - width == 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0.
- On error: resp = 10, rdata = 0, and the array is not modified.
- Array access happens on the clock edge that enters RESP. Word index = (addr - BASE_ADDR) >> 2.
- Write byte enables:
  - byte: 1 << addr[1:0];
  - halfword: 0011 << addr[1:0];
  - word: 1111.
- Write data lane steering: wdata is replicated (byte into all four lanes, halfword into both halves) and masked by the byte enables.
- Read: the addressed word is shifted right by 8*addr[1:0]. Byte reads zero bits [31:8]; halfword reads zero bits [31:16]; the LSU performs sign extension. rdata is nonzero only in a RESP cycle with read and OKAY, and is 0 otherwise.
- Write response: OKAY, rdata = 0.
- Reset mid-transaction (in WAIT or RESP) aborts the transaction with no response. A write that has not reached the RESP edge is not committed.

Optional Feature:
SCR1_DMEM_SRAM_PARITY_EN:
- Defined: the array stores 1 even-parity bit per byte. On write, the parity bit of each enabled byte is computed and inverted when inj_par_err_i = 1 (sampled at acceptance). On read, any parity mismatch in the enabled bytes returns resp = 10 and rdata = 0.
- Undefined: no parity storage, inj_par_err_i is ignored, and read errors arise only from address/width checks.

Test Plan:
- WAIT_CYCLES=0: write word 32'hDEAD_BEEF to 0x0001_0010, then read word from 0x0001_0010 -> ack in IDLE; resp = 01 one cycle after each acceptance; rdata = DEADBEEF.
- Byte write 32'h0000_00A5 to 0x0001_0013 over DEADBEEF -> word reads 0xA5ADBEEF; byte read at 0x...13 returns 0x000000A5; halfword read at 0x...12 returns 0x0000A5AD.
- Errors: read at 0x0000_FFFC (below window), word read at 0x0001_0002, width 11 -> each gives resp = 10 and rdata = 0; a subsequent read confirms no array change.
- WAIT_CYCLES=3: read with req held high through the response -> resp exactly 4 cycles after acceptance; ack low in WAIT/RESP; second acceptance on the cycle after RESP.
- Assert rst_n low in WAIT during a write to 0x0001_0020 -> no resp; a later read returns the old value; all outputs are 0 during reset.
- With SCR1_DMEM_SRAM_PARITY_EN: write word with inj_par_err_i = 1, then read -> resp = 10. Rewrite with inj = 0, then read -> resp = 01 with correct data.

Source files
------------

// File: rtl/scr1_dmem_sram_resp.sv
// scr1_dmem_sram_resp: dmem target with lane-steered SRAM, wait states and optional byte parity (SCR1_DMEM_SRAM_PARITY_EN)
module scr1_dmem_sram_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req_i,
  input  logic        dmem_cmd_i,
  input  logic [1:0]  dmem_width_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_req_ack_o,
  output logic [31:0] dmem_rdata_o,
  output logic [1:0]  dmem_resp_o,
  input  logic        inj_par_err_i
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int AW = IW + 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic cmd_q, rerr_q;
  logic [1:0] width_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, go, a_cmd, a_err, perr;
  logic [1:0] a_width;
  logic [31:0] a_addr, a_wdata, wrep, word, rd, rd_m;
  logic [3:0] be;
  logic [IW-1:0] idx;
  assign idle = state == IDLE;
  assign a_cmd = idle ? dmem_cmd_i : cmd_q;
  assign a_width = idle ? dmem_width_i : width_q;
  assign a_addr = idle ? dmem_addr_i : addr_q;
  assign a_wdata = idle ? dmem_wdata_i : wdata_q;
  assign a_err = (a_addr[31:AW] != BASE_ADDR[31:AW]) || (a_width == 2'b11) ||
                 (a_width == 2'b01 && a_addr[0]) || (a_width == 2'b10 && a_addr[1:0] != 2'b00);
  assign be = a_width == 2'b00 ? 4'b0001 << a_addr[1:0] : a_width == 2'b01 ? 4'b0011 << a_addr[1:0] : 4'b1111;
  assign wrep = a_width == 2'b00 ? {4{a_wdata[7:0]}} : a_width == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
  assign idx = a_addr[AW-1:2];
  assign word = mem[idx];
  assign rd = word >> {a_addr[1:0], 3'b000};
  assign rd_m = a_width == 2'b00 ? {24'b0, rd[7:0]} : a_width == 2'b01 ? {16'b0, rd[15:0]} : rd;
  // The array is accessed on the edge that enters RESP; reset blocks any commit.
  assign go = rst_n && ((idle && dmem_req_i && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1));
  // Next-state: accept in IDLE, count wait states, single RESP cycle.
  always_comb begin
    state_nx = IDLE;
    state_nx = idle ? (dmem_req_i ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
               state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  // State, request latch, wait counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      cmd_q <= 1'b0;
      width_q <= 2'b00;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      rerr_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      if (idle && dmem_req_i) begin
        cmd_q <= dmem_cmd_i;
        width_q <= dmem_width_i;
        addr_q <= dmem_addr_i;
        wdata_q <= dmem_wdata_i;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (go) begin
        rerr_q <= a_err || perr;
        rdata_q <= (a_cmd || a_err || perr) ? 32'd0 : rd_m;
      end
    end
  end
  // Byte-enabled store into the data array.
  always_ff @(posedge clk) begin
    if (go && a_cmd && !a_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  end
`ifdef SCR1_DMEM_SRAM_PARITY_EN
  logic inj_q, a_inj;
  logic [3:0] par [DEPTH_WORDS];
  assign a_inj = idle ? inj_par_err_i : inj_q;
  assign perr = !a_cmd && !a_err &&
                |(be & (par[idx] ^ {^word[31:24], ^word[23:16], ^word[15:8], ^word[7:0]}));
  // Injection request is captured with the rest of the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inj_q <= 1'b0;
    else if (idle && dmem_req_i) inj_q <= inj_par_err_i;
  end
  // Even parity per written byte, optionally corrupted for error injection.
  always_ff @(posedge clk) begin
    if (go && a_cmd && !a_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) par[idx][i] <= ^wrep[8*i +: 8] ^ a_inj;
  end
`else
  logic unused_inj;
  assign unused_inj = inj_par_err_i;
  assign perr = 1'b0;
`endif
  assign dmem_req_ack_o = rst_n && idle;
  assign dmem_resp_o = state == RESP ? (rerr_q ? 2'b10 : 2'b01) : 2'b00;
  assign dmem_rdata_o = state == RESP ? rdata_q : 32'd0;
endmodule

// File: tb/tb_scr1_dmem_sram_resp.sv
// tb_scr1_dmem_sram_resp: directed checks of a zero-wait and a three-wait responder
module tb_scr1_dmem_sram_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic cmd = 1'b0;
  logic [1:0] width = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic inj = 1'b0;
  logic [1:0] ack;
  logic [31:0] rdata0, rdata1;
  logic [1:0] resp0, resp1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  scr1_dmem_sram_resp u0 (
    .clk(clk), .rst_n(rst_n), .dmem_req_i(req[0]), .dmem_cmd_i(cmd), .dmem_width_i(width),
    .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_req_ack_o(ack[0]), .dmem_rdata_o(rdata0),
    .dmem_resp_o(resp0), .inj_par_err_i(inj)
  );
  scr1_dmem_sram_resp #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .dmem_req_i(req[1]), .dmem_cmd_i(cmd), .dmem_width_i(width),
    .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_req_ack_o(ack[1]), .dmem_rdata_o(rdata1),
    .dmem_resp_o(resp1), .inj_par_err_i(inj)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xact(input int s, input logic c, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic ij, input logic [1:0] er,
                      input logic [31:0] ed, input string tag);
    int n;
    @(negedge clk);
    cmd = c; width = w; addr = a; wdata = d; inj = ij; req[s] = 1'b1;
    n = 0;
    while (!ack[s] && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ack"}, 32'(ack[s]), 32'd1);
    @(negedge clk);
    req[s] = 1'b0;
    n = 1;
    while ((s ? resp1 : resp0) == 2'b00 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n, s ? 32'd4 : 32'd1);
    check({tag, "_resp"}, 32'(s ? resp1 : resp0), 32'(er));
    check({tag, "_rdata"}, s ? rdata1 : rdata0, ed);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_resp", {28'd0, resp1, resp0}, 32'd0);
    check("rst_rdata", rdata0 | rdata1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ack", 32'(ack), 32'd3);
    xact(0, 1, 2'b10, 32'h0001_0010, 32'hDEAD_BEEF, 0, 2'b01, 32'd0, "wr_word");
    xact(0, 0, 2'b10, 32'h0001_0010, 32'd0, 0, 2'b01, 32'hDEAD_BEEF, "rd_word");
    xact(0, 1, 2'b00, 32'h0001_0013, 32'h0000_00A5, 0, 2'b01, 32'd0, "wr_byte");
    xact(0, 0, 2'b10, 32'h0001_0010, 32'd0, 0, 2'b01, 32'hA5AD_BEEF, "rd_merged");
    xact(0, 0, 2'b00, 32'h0001_0013, 32'd0, 0, 2'b01, 32'h0000_00A5, "rd_byte3");
    xact(0, 0, 2'b01, 32'h0001_0012, 32'd0, 0, 2'b01, 32'h0000_A5AD, "rd_half2");
    xact(0, 0, 2'b00, 32'h0001_0010, 32'd0, 0, 2'b01, 32'h0000_00EF, "rd_byte0");
    xact(0, 0, 2'b01, 32'h0001_0010, 32'd0, 0, 2'b01, 32'h0000_BEEF, "rd_half0");
    xact(0, 0, 2'b10, 32'h0000_FFFC, 32'd0, 0, 2'b10, 32'd0, "err_below");
    xact(0, 0, 2'b10, 32'h0001_0002, 32'd0, 0, 2'b10, 32'd0, "err_walign");
    xact(0, 0, 2'b11, 32'h0001_0010, 32'd0, 0, 2'b10, 32'd0, "err_width");
    xact(0, 0, 2'b01, 32'h0001_0011, 32'd0, 0, 2'b10, 32'd0, "err_halign");
    xact(0, 0, 2'b10, 32'h0001_1000, 32'd0, 0, 2'b10, 32'd0, "err_above");
    xact(0, 1, 2'b10, 32'h0001_0FFC, 32'h1234_5678, 0, 2'b01, 32'd0, "wr_top");
    xact(0, 0, 2'b10, 32'h0001_0FFC, 32'd0, 0, 2'b01, 32'h1234_5678, "rd_top");
    xact(0, 1, 2'b10, 32'h0001_0000, 32'h0102_0304, 0, 2'b01, 32'd0, "wr_w0");
    xact(0, 1, 2'b01, 32'h0001_0001, 32'h0000_FFFF, 0, 2'b10, 32'd0, "werr_align");
    xact(0, 1, 2'b10, 32'h0001_1000, 32'hFFFF_FFFF, 0, 2'b10, 32'd0, "werr_range");
    xact(0, 1, 2'b11, 32'h0001_0000, 32'hFFFF_FFFF, 0, 2'b10, 32'd0, "werr_width");
    xact(0, 0, 2'b10, 32'h0001_0000, 32'd0, 0, 2'b01, 32'h0102_0304, "rd_w0_kept");
    xact(0, 0, 2'b10, 32'h0001_0010, 32'd0, 0, 2'b01, 32'hA5AD_BEEF, "rd_after_err");
    xact(1, 1, 2'b10, 32'h0001_0020, 32'h1111_1111, 0, 2'b01, 32'd0, "w3_wr");
    @(negedge clk);
    cmd = 1'b0; width = 2'b10; addr = 32'h0001_0020; req[1] = 1'b1;
    n = 0;
    while (!ack[1] && n < 20) begin @(negedge clk); n++; end
    check("hold_ack0", 32'(ack[1]), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("hold_wait_ack", 32'(ack[1]), 32'd0);
      check("hold_wait_resp", 32'(resp1), 32'd0);
    end
    @(negedge clk);
    check("hold_resp_ack", 32'(ack[1]), 32'd0);
    check("hold_resp", 32'(resp1), 32'd1);
    check("hold_rdata", rdata1, 32'h1111_1111);
    @(negedge clk);
    check("hold_ack2", 32'(ack[1]), 32'd1);
    @(negedge clk);
    req[1] = 1'b0;
    n = 1;
    while (resp1 == 2'b00 && n < 20) begin @(negedge clk); n++; end
    check("hold2_lat", n, 32'd4);
    check("hold2_rdata", rdata1, 32'h1111_1111);
    @(negedge clk);
    cmd = 1'b1; width = 2'b10; addr = 32'h0001_0020; wdata = 32'h2222_2222; req[1] = 1'b1;
    n = 0;
    while (!ack[1] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_out", rdata0 | rdata1 | {28'd0, resp1, resp0}, 32'd0);
    end
    rst_n = 1'b1;
    xact(1, 0, 2'b10, 32'h0001_0020, 32'd0, 0, 2'b01, 32'h1111_1111, "rst_no_commit");
`ifdef SCR1_DMEM_SRAM_PARITY_EN
    xact(0, 1, 2'b10, 32'h0001_0030, 32'hCAFE_F00D, 1, 2'b01, 32'd0, "par_wr_inj");
    xact(0, 0, 2'b10, 32'h0001_0030, 32'd0, 0, 2'b10, 32'd0, "par_rd_bad");
    xact(0, 1, 2'b10, 32'h0001_0030, 32'hCAFE_F00D, 0, 2'b01, 32'd0, "par_wr_ok");
    xact(0, 0, 2'b10, 32'h0001_0030, 32'd0, 0, 2'b01, 32'hCAFE_F00D, "par_rd_ok");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
